// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_ctrl
// Purpose  : Run / halt / single-step controller producing the one-cycle
//            clock-enable tick that gates every datapath register.
//            Raw panel buttons are synchronized, debounced and edge-detected
//            into press pulses which drive a four-state control FSM.
// Revision : 1.0  initial release
// ============================================================================
module clock_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DELAY_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run_btn_i,
   input  logic               step_btn_i,
   input  logic               hlt_i,
   input  logic [DELAY_W-1:0] delay_i,
   output logic               tick_o,
   output logic               running_o,
   output logic               halted_o
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1 before the flip.
   localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [DELAY_W-1:0] RATE_ONE = DELAY_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HLTD = 2'd3
   } state_t;

   // Bit 0 = run button, bit 1 = step button.
   logic [1:0] w_btn_raw;
   logic [1:0] w_press;

   assign w_btn_raw = {step_btn_i, run_btn_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic            sync1_q;
         logic            sync2_q;
         logic            level_q;
         logic            level_prev_q;
         logic            press_q;
         logic [DB_W-1:0] db_cnt_q;
         logic [DB_W-1:0] db_cnt_d;

         assign db_cnt_d = db_cnt_q + DB_ONE;

         // Synchronize, debounce and turn a rising debounced level into a one-cycle press.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q      <= 1'b0;
               sync2_q      <= 1'b0;
               level_q      <= 1'b0;
               level_prev_q <= 1'b0;
               press_q      <= 1'b0;
               db_cnt_q     <= '0;
            end else begin
               sync1_q <= w_btn_raw[gi];
               sync2_q <= sync1_q;
               if (sync2_q != level_q) begin
                  // A run of disagreeing samples long enough flips the accepted level.
                  if (db_cnt_q == DB_LAST) begin
                     level_q  <= sync2_q;
                     db_cnt_q <= '0;
                  end else begin
                     db_cnt_q <= db_cnt_d;
                  end
               end else begin
                  db_cnt_q <= '0;
               end
               level_prev_q <= level_q;
               press_q      <= level_q & ~level_prev_q;
            end
         end

         assign w_press[gi] = press_q;
      end
   endgenerate

   state_t             state_q;
   logic               tick_q;
   logic               running_q;
   logic               halted_q;
   logic [DELAY_W-1:0] rate_cnt_q;
   logic [DELAY_W-1:0] rate_cnt_d;

   assign rate_cnt_d = rate_cnt_q + RATE_ONE;

   // Control FSM with registered outputs; hlt beats run press beats step press beats rate counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tick_q     <= 1'b0;
         running_q  <= 1'b0;
         halted_q   <= 1'b0;
         rate_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tick_q <= 1'b0;
               if (hlt_i) begin
                  state_q  <= S_HLTD;
                  halted_q <= 1'b1;
               end else if (w_press[0]) begin
                  state_q    <= S_RUN;
                  running_q  <= 1'b1;
                  rate_cnt_q <= '0;
               end else if (w_press[1]) begin
                  // The step tick is asserted for the whole STEP cycle.
                  state_q <= S_STEP;
                  tick_q  <= 1'b1;
               end
            end
            S_STEP: begin
               tick_q <= 1'b0;
               if (hlt_i) begin
                  state_q  <= S_HLTD;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (hlt_i) begin
                  state_q   <= S_HLTD;
                  tick_q    <= 1'b0;
                  running_q <= 1'b0;
                  halted_q  <= 1'b1;
               end else if (w_press[0]) begin
                  state_q   <= S_IDLE;
                  tick_q    <= 1'b0;
                  running_q <= 1'b0;
               end else if (rate_cnt_q >= delay_i) begin
                  // Live compare: a lowered delay ticks at once instead of wrapping.
                  tick_q     <= 1'b1;
                  rate_cnt_q <= '0;
               end else begin
                  tick_q     <= 1'b0;
                  rate_cnt_q <= rate_cnt_d;
               end
            end
            S_HLTD: begin
               tick_q    <= 1'b0;
               running_q <= 1'b0;
               halted_q  <= 1'b1;
            end
            default: begin
               state_q   <= S_IDLE;
               tick_q    <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign tick_o    = tick_q;
   assign running_o = running_q;
   assign halted_o  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_ctrl
// Purpose  : Self-checking bench for clock_ctrl. A cycle-indexed reference
//            model (button sample histories + mode/counter arithmetic)
//            predicts tick/running/halted after every clock edge; directed
//            phases add latency, rate and halt checks on top.
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_ctrl;

   localparam int D      = 4;
   localparam int W      = 8;
   localparam int MAXC   = 8000;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STEP = 2;
   localparam int M_HALT = 3;

   logic         clk      = 1'b0;
   logic         rst      = 1'b0;
   logic         run_btn  = 1'b0;
   logic         step_btn = 1'b0;
   logic         hlt      = 1'b0;
   logic [W-1:0] delay    = '0;
   logic         tick;
   logic         running;
   logic         halted;

   int n_cmp    = 0;
   int n_bad    = 0;
   int tick_cnt = 0;

   clock_ctrl #(.DEBOUNCE_CYCLES(D), .DELAY_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .run_btn_i  (run_btn),
      .step_btn_i (step_btn),
      .hlt_i      (hlt),
      .delay_i    (delay),
      .tick_o     (tick),
      .running_o  (running),
      .halted_o   (halted)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int  n        = 0;   // index of the most recent clock edge
   int  last_rst = 0;   // last edge at which reset was in effect
   bit  hist_b [2][MAXC];
   bit  lvl_b  [2][MAXC];
   int  run_b  [2][MAXC];
   int  m_mode = M_IDLE;
   int  m_cnt  = 0;
   bit  e_tick = 1'b0;
   bit  e_run  = 1'b0;
   bit  e_halt = 1'b0;

   function automatic bit lvl_at(input int b, input int k);
      return (k > last_rst && k < MAXC) ? lvl_b[b][k] : 1'b0;
   endfunction

   function automatic int run_at(input int b, input int k);
      return (k > last_rst && k < MAXC) ? run_b[b][k] : 0;
   endfunction

   // Synchronized sample seen by the debouncer at edge k: raw value two edges earlier.
   function automatic bit samp_at(input int b, input int k);
      return (k - 2 > last_rst) ? hist_b[b][k-2] : 1'b0;
   endfunction

   // Press visible to the FSM at edge k: debounced level rose two/three edges before.
   function automatic bit press_at(input int b, input int k);
      return lvl_at(b, k - 2) & ~lvl_at(b, k - 3);
   endfunction

   task automatic model_reset();
      last_rst = n;
      m_mode   = M_IDLE;
      m_cnt    = 0;
      e_tick   = 1'b0;
      e_run    = 1'b0;
      e_halt   = 1'b0;
   endtask

   task automatic model_edge();
      bit s, pl, nl, rp, sp;
      int pr;
      n++;
      if (n >= MAXC) begin
         $display("FAIL model_range: edge %0d exceeds history %0d", n, MAXC);
         n_bad++;
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $fatal(1, "history overflow");
      end
      if (rst) begin
         model_reset();
         return;
      end
      hist_b[0][n] = run_btn;
      hist_b[1][n] = step_btn;
      for (int b = 0; b < 2; b++) begin
         s  = samp_at(b, n);
         pl = lvl_at(b, n - 1);
         pr = run_at(b, n - 1);
         nl = pl;
         if (s != pl) begin
            pr++;
            if (pr == D) begin
               nl = ~pl;
               pr = 0;
            end
         end else begin
            pr = 0;
         end
         lvl_b[b][n] = nl;
         run_b[b][n] = pr;
      end
      rp     = press_at(0, n);
      sp     = press_at(1, n);
      e_tick = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (hlt)     begin m_mode = M_HALT; e_halt = 1'b1; end
            else if (rp) begin m_mode = M_RUN; e_run = 1'b1; m_cnt = 0; end
            else if (sp) begin m_mode = M_STEP; e_tick = 1'b1; end
         end
         M_STEP: begin
            if (hlt) begin m_mode = M_HALT; e_halt = 1'b1; end
            else         m_mode = M_IDLE;
         end
         M_RUN: begin
            if (hlt)     begin m_mode = M_HALT; e_run = 1'b0; e_halt = 1'b1; end
            else if (rp) begin m_mode = M_IDLE; e_run = 1'b0; end
            else if (m_cnt >= int'(delay)) begin e_tick = 1'b1; m_cnt = 0; end
            else m_cnt++;
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("tick", int'(tick), int'(e_tick));
      chk("running", int'(running), int'(e_run));
      chk("halted", int'(halted), int'(e_halt));
      if (tick) tick_cnt++;
   endtask

   task automatic do_rst(input int k);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_tick", int'(tick), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_halted", int'(halted), 0);
      for (int i = 0; i < k; i++) begin
         run_btn  = 1'($urandom_range(0, 1));
         step_btn = 1'($urandom_range(0, 1));
         cyc();
      end
      rst      = 1'b0;
      run_btn  = 1'b0;
      step_btn = 1'b0;
   endtask

   task automatic press(input bit r, input bit s, input int hold);
      run_btn  = r;
      step_btn = s;
      repeat (hold) cyc();
      run_btn  = 1'b0;
      step_btn = 1'b0;
   endtask

   task automatic wait_tick(input int maxc, input string tag, output int waited);
      waited = 0;
      for (int i = 0; i < maxc; i++) begin
         cyc();
         waited++;
         if (tick) return;
      end
      chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_running(input bit want, input int maxc, input string tag);
      for (int i = 0; i < maxc; i++) begin
         if (running == want) break;
         cyc();
      end
      chk(tag, int'(running), int'(want));
   endtask

   int base, e0, first, waited, hold_r, hold_s;

   initial begin
      // T1: reset with bouncing buttons
      do_rst(8);
      chk("t1_ticks_in_reset", tick_cnt, 0);
      repeat (3) cyc();

      // T2: single step, press latency and one tick only
      base     = tick_cnt;
      first    = -1;
      e0       = n + 1;
      step_btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (tick && first < 0) first = n - e0;
      end
      step_btn = 1'b0;
      repeat (20) cyc();
      chk("t2_latency", first, D + 3);
      chk("t2_ticks", tick_cnt - base, 1);

      // T3: run mode rates
      delay = W'(3);
      press(1'b1, 1'b0, 10);
      wait_running(1'b1, 20, "t3_running");
      wait_tick(20, "t3_align", waited);
      base = tick_cnt;
      repeat (40) cyc();
      chk("t3_delay3_ticks", tick_cnt - base, 10);
      delay = W'(0);
      repeat (5) cyc();
      base = tick_cnt;
      repeat (20) cyc();
      chk("t3_delay0_ticks", tick_cnt - base, 20);
      delay = W'(255);
      wait_tick(600, "t3_align255", waited);
      wait_tick(600, "t3_period255", waited);
      chk("t3_period255", waited, 256);
      press(1'b1, 1'b0, 8);
      wait_running(1'b0, 20, "t3_exit");

      // T4: 1-on/1-off bounce on step never yields a press
      base = tick_cnt;
      for (int i = 0; i < 30; i++) begin
         step_btn = (i % 2 == 0);
         cyc();
      end
      step_btn = 1'b0;
      repeat (20) cyc();
      chk("t4_bounce_ticks", tick_cnt - base, 0);

      // T5: halt from RUN
      delay = W'(0);
      press(1'b1, 1'b0, 10);
      wait_running(1'b1, 20, "t5_running");
      repeat (5) cyc();
      hlt = 1'b1;
      cyc();
      hlt = 1'b0;
      chk("t5_no_tick", int'(tick), 0);
      chk("t5_halted", int'(halted), 1);
      base = tick_cnt;
      press(1'b0, 1'b1, 10);
      repeat (5) cyc();
      press(1'b1, 1'b0, 10);
      repeat (10) cyc();
      chk("t5_ticks_while_halted", tick_cnt - base, 0);
      chk("t5_still_halted", int'(halted), 1);
      do_rst(3);
      cyc();
      chk("t5_rst_clears", int'(halted), 0);

      // T6: simultaneous presses and a live delay reduction
      delay = W'(200);
      base  = tick_cnt;
      press(1'b1, 1'b1, 10);
      wait_running(1'b1, 20, "t6_run_wins");
      repeat (30) cyc();
      chk("t6_no_step_tick", tick_cnt - base, 0);
      for (int i = 0; i < 300; i++) begin
         if (m_cnt == 150) break;
         cyc();
      end
      chk("t6_cnt_reached", m_cnt, 150);
      delay = W'(5);
      cyc();
      chk("t6_next_tick", int'(tick), 1);
      wait_tick(20, "t6_period", waited);
      chk("t6_period", waited, 6);

      // Randomized traffic against the model
      do_rst(2);
      hold_r = 0;
      hold_s = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_r == 0) begin
            run_btn = 1'($urandom_range(0, 1));
            hold_r  = $urandom_range(1, 12);
         end else hold_r--;
         if (hold_s == 0) begin
            step_btn = 1'($urandom_range(0, 1));
            hold_s   = $urandom_range(1, 12);
         end else hold_s--;
         hlt = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 63) == 0) delay = W'($urandom_range(0, 6));
         if ($urandom_range(0, 299) == 0) do_rst($urandom_range(1, 4));
         cyc();
      end
      hlt = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
